// File: rtl/pipelined_control_pkg.sv
// pipeline_ctrl_pkg: opcode map, control encodings and per-stage control structs for the pipelined decoder
package pipeline_ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [3:0] ALU_RR  = 4'b0000;
  localparam logic [3:0] ALU_RI  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_BR  = 4'b0011;
  localparam logic [1:0] A_RS1  = 2'b00;
  localparam logic [1:0] A_PC   = 2'b01;
  localparam logic [1:0] A_ZERO = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic [1:0] auipc_lui;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal;
  } ctrl_t;
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
  } mem_ctrl_t;
  typedef struct packed {
    logic       reg_write;
    logic [1:0] wb_sel;
  } wb_ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
  function automatic ctrl_t decode(input logic [6:0] op);
    ctrl_t c;
    c = CTRL_BUBBLE;
    case (op)
      OP_R:      c.reg_write = 1'b1;
      OP_IMM:    begin c.alu_op = ALU_RI; c.alu_src = 1'b1; c.reg_write = 1'b1; end
      OP_LOAD:   begin c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.mem_read = 1'b1; c.reg_write = 1'b1; c.wb_sel = WB_MEM; end
      OP_STORE:  begin c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.mem_write = 1'b1; end
      OP_BRANCH: begin c.alu_op = ALU_BR; c.branch = 1'b1; end
      OP_LUI:    begin c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.auipc_lui = A_ZERO; c.reg_write = 1'b1; end
      OP_AUIPC:  begin c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.auipc_lui = A_PC; c.reg_write = 1'b1; end
      OP_JAL:    begin c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.auipc_lui = A_PC; c.jump = 1'b1; c.reg_write = 1'b1; c.wb_sel = WB_PC4; end
      OP_JALR:   begin c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.jump = 1'b1; c.reg_write = 1'b1; c.wb_sel = WB_PC4; end
      default:   c.illegal = 1'b1;
    endcase
    return c;
  endfunction
  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  endfunction
  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction
endpackage

// File: rtl/pipelined_control_if.sv
// pipelined_control_if: ID-stage instruction fields in, hazard and per-stage control outputs back
interface pipelined_control_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4
);
  logic [6:0]            i_opcode;
  logic [REG_ADDR_W-1:0] i_rs1;
  logic [REG_ADDR_W-1:0] i_rs2;
  logic [REG_ADDR_W-1:0] i_rd;
  logic                  i_branch_taken;
  logic                  o_stall;
  logic                  o_flush;
  logic [ALU_OP_W-1:0]   o_ex_alu_op;
  logic                  o_ex_alu_src;
  logic [1:0]            o_ex_auipc_lui;
  logic [1:0]            o_ex_fwd_a;
  logic [1:0]            o_ex_fwd_b;
  logic                  o_ex_illegal;
  logic                  o_mem_read;
  logic                  o_mem_write;
  logic                  o_wb_reg_write;
  logic [1:0]            o_wb_sel;
  modport master (
    output i_opcode, i_rs1, i_rs2, i_rd, i_branch_taken,
    input  o_stall, o_flush, o_ex_alu_op, o_ex_alu_src, o_ex_auipc_lui, o_ex_fwd_a, o_ex_fwd_b,
           o_ex_illegal, o_mem_read, o_mem_write, o_wb_reg_write, o_wb_sel
  );
  modport slave (
    input  i_opcode, i_rs1, i_rs2, i_rd, i_branch_taken,
    output o_stall, o_flush, o_ex_alu_op, o_ex_alu_src, o_ex_auipc_lui, o_ex_fwd_a, o_ex_fwd_b,
           o_ex_illegal, o_mem_read, o_mem_write, o_wb_reg_write, o_wb_sel
  );
endinterface

// File: rtl/pipelined_control_hazard_forward_unit.sv
// hazard_forward_unit: load-use / RAW stall, control-transfer flush and EX operand forwarding selects
module hazard_forward_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int ENABLE_FORWARDING = 1
) (
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic [REG_ADDR_W-1:0] i_idex_rs1,
  input  logic [REG_ADDR_W-1:0] i_idex_rs2,
  input  logic [REG_ADDR_W-1:0] i_idex_rd,
  input  logic                  i_idex_rw,
  input  logic                  i_idex_mem_read,
  input  logic                  i_idex_branch,
  input  logic                  i_idex_jump,
  input  logic                  i_branch_taken,
  input  logic [REG_ADDR_W-1:0] i_exmem_rd,
  input  logic                  i_exmem_rw,
  input  logic [REG_ADDR_W-1:0] i_memwb_rd,
  input  logic                  i_memwb_rw,
  output logic                  o_stall,
  output logic                  o_flush,
  output logic [1:0]            o_fwd_a,
  output logic [1:0]            o_fwd_b
);
  logic w_load_use, w_raw;
  // Unused sources arrive as index 0, so a zero index never matches
  function automatic logic hit(input logic rw, input logic [REG_ADDR_W-1:0] rd, input logic [REG_ADDR_W-1:0] rs);
    return rw && rs != '0 && rd == rs;
  endfunction
  function automatic logic [1:0] fwd(input logic [REG_ADDR_W-1:0] rs);
    return ENABLE_FORWARDING == 0         ? FWD_NONE :
           hit(i_exmem_rw, i_exmem_rd, rs) ? FWD_EXMEM :
           hit(i_memwb_rw, i_memwb_rd, rs) ? FWD_MEMWB : FWD_NONE;
  endfunction
  always_comb begin
    w_load_use = i_idex_mem_read && (hit(1'b1, i_idex_rd, i_id_rs1) || hit(1'b1, i_idex_rd, i_id_rs2));
    w_raw = hit(i_idex_rw, i_idex_rd, i_id_rs1) || hit(i_idex_rw, i_idex_rd, i_id_rs2) ||
            hit(i_exmem_rw, i_exmem_rd, i_id_rs1) || hit(i_exmem_rw, i_exmem_rd, i_id_rs2) ||
            hit(i_memwb_rw, i_memwb_rd, i_id_rs1) || hit(i_memwb_rw, i_memwb_rd, i_id_rs2);
    o_flush = i_idex_jump || (i_idex_branch && i_branch_taken);
    o_stall = !o_flush && (w_load_use || (ENABLE_FORWARDING == 0 && w_raw));
    o_fwd_a = fwd(i_idex_rs1);
    o_fwd_b = fwd(i_idex_rs2);
  end
endmodule

// File: rtl/pipelined_control.sv
// pipelined_control: ID-stage decoder feeding ID/EX, EX/MEM and MEM/WB control registers with hazard handling
module pipelined_control
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int ALU_OP_W          = 4,
  parameter int ENABLE_FORWARDING = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  pipelined_control_if.slave bus
);
  ctrl_t                 w_dec, r_idex_ctrl;
  mem_ctrl_t             r_exmem_ctrl;
  wb_ctrl_t              r_memwb_ctrl;
  logic [REG_ADDR_W-1:0] w_rs1, w_rs2, r_idex_rd, r_idex_rs1, r_idex_rs2, r_exmem_rd, r_memwb_rd;
  logic                  w_stall, w_flush, w_bubble;
  logic [1:0]            w_fwd_a, w_fwd_b;
  always_comb begin
    w_dec = decode(bus.i_opcode);
    w_dec.reg_write = w_dec.reg_write && bus.i_rd != '0;
    w_rs1 = uses_rs1(bus.i_opcode) ? bus.i_rs1 : '0;
    w_rs2 = uses_rs2(bus.i_opcode) ? bus.i_rs2 : '0;
  end
  hazard_forward_unit #(
    .REG_ADDR_W        (REG_ADDR_W),
    .ENABLE_FORWARDING (ENABLE_FORWARDING)
  ) u_hfu (
    .i_id_rs1        (w_rs1),
    .i_id_rs2        (w_rs2),
    .i_idex_rs1      (r_idex_rs1),
    .i_idex_rs2      (r_idex_rs2),
    .i_idex_rd       (r_idex_rd),
    .i_idex_rw       (r_idex_ctrl.reg_write),
    .i_idex_mem_read (r_idex_ctrl.mem_read),
    .i_idex_branch   (r_idex_ctrl.branch),
    .i_idex_jump     (r_idex_ctrl.jump),
    .i_branch_taken  (bus.i_branch_taken),
    .i_exmem_rd      (r_exmem_rd),
    .i_exmem_rw      (r_exmem_ctrl.reg_write),
    .i_memwb_rd      (r_memwb_rd),
    .i_memwb_rw      (r_memwb_ctrl.reg_write),
    .o_stall         (w_stall),
    .o_flush         (w_flush),
    .o_fwd_a         (w_fwd_a),
    .o_fwd_b         (w_fwd_b)
  );
  assign w_bubble = w_stall || w_flush;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idex_ctrl  <= CTRL_BUBBLE;
      r_idex_rd    <= '0;
      r_idex_rs1   <= '0;
      r_idex_rs2   <= '0;
      r_exmem_ctrl <= '0;
      r_exmem_rd   <= '0;
      r_memwb_ctrl <= '0;
      r_memwb_rd   <= '0;
    end else begin
      r_idex_ctrl  <= w_bubble ? CTRL_BUBBLE : w_dec;
      r_idex_rd    <= w_bubble ? '0 : bus.i_rd;
      r_idex_rs1   <= w_bubble ? '0 : w_rs1;
      r_idex_rs2   <= w_bubble ? '0 : w_rs2;
      r_exmem_ctrl <= '{r_idex_ctrl.mem_read, r_idex_ctrl.mem_write, r_idex_ctrl.reg_write, r_idex_ctrl.wb_sel};
      r_exmem_rd   <= r_idex_rd;
      r_memwb_ctrl <= '{r_exmem_ctrl.reg_write, r_exmem_ctrl.wb_sel};
      r_memwb_rd   <= r_exmem_rd;
    end
  end
  assign bus.o_stall        = w_stall;
  assign bus.o_flush        = w_flush;
  assign bus.o_ex_alu_op    = ALU_OP_W'(r_idex_ctrl.alu_op);
  assign bus.o_ex_alu_src   = r_idex_ctrl.alu_src;
  assign bus.o_ex_auipc_lui = r_idex_ctrl.auipc_lui;
  assign bus.o_ex_fwd_a     = w_fwd_a;
  assign bus.o_ex_fwd_b     = w_fwd_b;
  assign bus.o_ex_illegal   = r_idex_ctrl.illegal;
  assign bus.o_mem_read     = r_exmem_ctrl.mem_read;
  assign bus.o_mem_write    = r_exmem_ctrl.mem_write;
  assign bus.o_wb_reg_write = r_memwb_ctrl.reg_write;
  assign bus.o_wb_sel       = r_memwb_ctrl.wb_sel;
endmodule

// File: tb/tb_pipelined_control.sv
// tb_pipelined_control: directed scenarios on a forwarding instance (b0) and a stall-only instance (b1)
module tb_pipelined_control;
  import pipeline_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  pipelined_control_if #(.REG_ADDR_W(5), .ALU_OP_W(4)) b0 ();
  pipelined_control_if #(.REG_ADDR_W(5), .ALU_OP_W(4)) b1 ();
  pipelined_control #(.REG_ADDR_W(5), .ALU_OP_W(4), .ENABLE_FORWARDING(1)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));
  pipelined_control #(.REG_ADDR_W(5), .ALU_OP_W(4), .ENABLE_FORWARDING(0)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));
  function automatic logic [18:0] outs0();
    return {b0.o_ex_alu_op, b0.o_ex_alu_src, b0.o_ex_auipc_lui, b0.o_ex_fwd_a, b0.o_ex_fwd_b, b0.o_ex_illegal,
            b0.o_mem_read, b0.o_mem_write, b0.o_wb_reg_write, b0.o_wb_sel, b0.o_stall, b0.o_flush};
  endfunction
  function automatic logic [18:0] outs1();
    return {b1.o_ex_alu_op, b1.o_ex_alu_src, b1.o_ex_auipc_lui, b1.o_ex_fwd_a, b1.o_ex_fwd_b, b1.o_ex_illegal,
            b1.o_mem_read, b1.o_mem_write, b1.o_wb_reg_write, b1.o_wb_sel, b1.o_stall, b1.o_flush};
  endfunction
  task automatic set(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic bt = 1'b0);
    b0.i_opcode = op; b0.i_rd = rd; b0.i_rs1 = rs1; b0.i_rs2 = rs2; b0.i_branch_taken = bt;
    b1.i_opcode = op; b1.i_rd = rd; b1.i_rs1 = rs1; b1.i_rs2 = rs2; b1.i_branch_taken = bt;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic nops();
    set(OP_IMM, 0, 0, 0);
    repeat (4) tick();
  endtask
  task automatic test_reset();
    set(OP_IMM, 0, 0, 0);
    checks++; if (outs0() !== 19'd0) begin errors++; $display("FAIL reset_fwd_outputs got=%h want=0", outs0()); end
    checks++; if (outs1() !== 19'd0) begin errors++; $display("FAIL reset_nofwd_outputs got=%h want=0", outs1()); end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    nops();
  endtask
  task automatic test_add();
    set(OP_R, 3, 1, 2);
    tick();
    checks++; if (b0.o_ex_alu_op !== ALU_RR) begin errors++; $display("FAIL add_ex_alu_op got=%b want=%b", b0.o_ex_alu_op, ALU_RR); end
    checks++; if (b0.o_ex_alu_src !== 1'b0) begin errors++; $display("FAIL add_ex_alu_src got=%b want=0", b0.o_ex_alu_src); end
    set(OP_IMM, 0, 0, 0);
    tick();
    checks++; if ({b0.o_mem_read, b0.o_mem_write} !== 2'b00) begin errors++; $display("FAIL add_mem got=%b want=00", {b0.o_mem_read, b0.o_mem_write}); end
    checks++; if (b0.o_ex_alu_op !== ALU_RI) begin errors++; $display("FAIL nop_ex_alu_op got=%b want=%b", b0.o_ex_alu_op, ALU_RI); end
    tick();
    checks++; if ({b0.o_wb_reg_write, b0.o_wb_sel} !== 3'b100) begin errors++; $display("FAIL add_wb got=%b want=100", {b0.o_wb_reg_write, b0.o_wb_sel}); end
    set(OP_LOAD, 5, 1, 0);
    tick();
    checks++; if ({b0.o_ex_alu_op, b0.o_ex_alu_src} !== 5'b00101) begin errors++; $display("FAIL lw_ex got=%b want=00101", {b0.o_ex_alu_op, b0.o_ex_alu_src}); end
    set(OP_IMM, 0, 0, 0);
    tick();
    checks++; if (b0.o_mem_read !== 1'b1) begin errors++; $display("FAIL lw_mem_read got=%b want=1", b0.o_mem_read); end
    rst_n = 1'b0;
    #1;
    checks++; if (outs0() !== 19'd0) begin errors++; $display("FAIL midreset_outputs got=%h want=0", outs0()); end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    nops();
  endtask
  task automatic test_load_use();
    set(OP_LOAD, 5, 1, 0);
    checks++; if (b0.o_stall !== 1'b0) begin errors++; $display("FAIL lu_pre_stall got=%b want=0", b0.o_stall); end
    tick();
    set(OP_R, 6, 5, 2);
    checks++; if (b0.o_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b want=1", b0.o_stall); end
    tick();
    checks++; if ({b0.o_ex_alu_op, b0.o_ex_alu_src, b0.o_ex_fwd_a} !== 7'd0) begin errors++; $display("FAIL lu_bubble got=%b want=0", {b0.o_ex_alu_op, b0.o_ex_alu_src, b0.o_ex_fwd_a}); end
    checks++; if (b0.o_mem_read !== 1'b1) begin errors++; $display("FAIL lu_mem_read got=%b want=1", b0.o_mem_read); end
    checks++; if (b0.o_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_release got=%b want=0", b0.o_stall); end
    tick();
    checks++; if ({b0.o_ex_fwd_a, b0.o_ex_fwd_b} !== {FWD_MEMWB, FWD_NONE}) begin errors++; $display("FAIL lu_fwd got=%b want=0100", {b0.o_ex_fwd_a, b0.o_ex_fwd_b}); end
    checks++; if ({b0.o_wb_reg_write, b0.o_wb_sel} !== 3'b101) begin errors++; $display("FAIL lu_wb got=%b want=101", {b0.o_wb_reg_write, b0.o_wb_sel}); end
    nops();
  endtask
  task automatic test_raw_fwd();
    set(OP_R, 4, 1, 2);
    tick();
    set(OP_R, 4, 1, 2);
    tick();
    set(OP_R, 7, 4, 4);
    checks++; if (b0.o_stall !== 1'b0) begin errors++; $display("FAIL raw_no_stall got=%b want=0", b0.o_stall); end
    tick();
    checks++; if ({b0.o_ex_fwd_a, b0.o_ex_fwd_b} !== {FWD_EXMEM, FWD_EXMEM}) begin errors++; $display("FAIL raw_fwd_exmem got=%b want=1010", {b0.o_ex_fwd_a, b0.o_ex_fwd_b}); end
    set(OP_R, 8, 4, 2);
    tick();
    checks++; if ({b0.o_ex_fwd_a, b0.o_ex_fwd_b} !== {FWD_MEMWB, FWD_NONE}) begin errors++; $display("FAIL raw_fwd_memwb got=%b want=0100", {b0.o_ex_fwd_a, b0.o_ex_fwd_b}); end
    nops();
    set(OP_R, 0, 1, 2);
    tick();
    set(OP_R, 7, 0, 0);
    tick();
    checks++; if ({b0.o_ex_fwd_a, b0.o_ex_fwd_b} !== 4'b0000) begin errors++; $display("FAIL x0_fwd got=%b want=0000", {b0.o_ex_fwd_a, b0.o_ex_fwd_b}); end
    set(OP_IMM, 0, 0, 0);
    tick();
    checks++; if (b0.o_wb_reg_write !== 1'b0) begin errors++; $display("FAIL x0_wb_reg_write got=%b want=0", b0.o_wb_reg_write); end
    nops();
  endtask
  task automatic test_branch();
    set(OP_BRANCH, 0, 1, 2);
    tick();
    set(OP_IMM, 5, 1, 0, 1'b1);
    checks++; if ({b0.o_flush, b0.o_stall} !== 2'b10) begin errors++; $display("FAIL br_taken_flush got=%b want=10", {b0.o_flush, b0.o_stall}); end
    checks++; if (b0.o_ex_alu_op !== ALU_BR) begin errors++; $display("FAIL br_ex_alu_op got=%b want=%b", b0.o_ex_alu_op, ALU_BR); end
    tick();
    checks++; if ({b0.o_ex_alu_op, b0.o_ex_alu_src} !== 5'd0) begin errors++; $display("FAIL br_squash got=%b want=0", {b0.o_ex_alu_op, b0.o_ex_alu_src}); end
    checks++; if (b0.o_flush !== 1'b0) begin errors++; $display("FAIL br_flush_once got=%b want=0", b0.o_flush); end
    set(OP_BRANCH, 0, 1, 2);
    tick();
    set(OP_IMM, 5, 1, 0, 1'b0);
    checks++; if (b0.o_flush !== 1'b0) begin errors++; $display("FAIL br_not_taken got=%b want=0", b0.o_flush); end
    tick();
    checks++; if (b0.o_ex_alu_op !== ALU_RI) begin errors++; $display("FAIL br_fallthrough got=%b want=%b", b0.o_ex_alu_op, ALU_RI); end
    nops();
    set(OP_JAL, 1, 0, 0);
    tick();
    set(OP_R, 3, 1, 2);
    checks++; if ({b1.o_flush, b1.o_stall} !== 2'b10) begin errors++; $display("FAIL flush_wins got=%b want=10", {b1.o_flush, b1.o_stall}); end
    nops();
  endtask
  task automatic test_jumps();
    set(OP_JAL, 1, 0, 0);
    tick();
    set(OP_IMM, 0, 0, 0);
    checks++; if (b0.o_ex_auipc_lui !== A_PC) begin errors++; $display("FAIL jal_auipc_lui got=%b want=01", b0.o_ex_auipc_lui); end
    checks++; if (b0.o_flush !== 1'b1) begin errors++; $display("FAIL jal_flush got=%b want=1", b0.o_flush); end
    tick();
    checks++; if (b0.o_ex_alu_op !== ALU_RR) begin errors++; $display("FAIL jal_squash got=%b want=0000", b0.o_ex_alu_op); end
    set(OP_JALR, 0, 1, 0);
    tick();
    checks++; if ({b0.o_ex_auipc_lui, b0.o_ex_alu_src, b0.o_ex_fwd_a} !== 5'b00101) begin errors++; $display("FAIL jalr_ex got=%b want=00101", {b0.o_ex_auipc_lui, b0.o_ex_alu_src, b0.o_ex_fwd_a}); end
    checks++; if ({b0.o_wb_reg_write, b0.o_wb_sel} !== 3'b110) begin errors++; $display("FAIL jal_wb got=%b want=110", {b0.o_wb_reg_write, b0.o_wb_sel}); end
    set(OP_IMM, 0, 0, 0);
    checks++; if (b0.o_flush !== 1'b1) begin errors++; $display("FAIL jalr_flush got=%b want=1", b0.o_flush); end
    tick();
    tick();
    checks++; if ({b0.o_wb_reg_write, b0.o_wb_sel} !== 3'b010) begin errors++; $display("FAIL jalr_wb got=%b want=010", {b0.o_wb_reg_write, b0.o_wb_sel}); end
    set(OP_LUI, 3, 0, 0);
    tick();
    checks++; if (b0.o_ex_auipc_lui !== A_ZERO) begin errors++; $display("FAIL lui_auipc_lui got=%b want=10", b0.o_ex_auipc_lui); end
    set(OP_AUIPC, 4, 0, 0);
    tick();
    set(OP_IMM, 0, 0, 0);
    checks++; if (b0.o_ex_auipc_lui !== A_PC) begin errors++; $display("FAIL auipc_auipc_lui got=%b want=01", b0.o_ex_auipc_lui); end
    checks++; if (b0.o_flush !== 1'b0) begin errors++; $display("FAIL auipc_no_flush got=%b want=0", b0.o_flush); end
    nops();
  endtask
  task automatic test_illegal_store();
    set(7'b1111111, 5, 1, 2);
    tick();
    set(OP_STORE, 0, 1, 2);
    checks++; if (b0.o_ex_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got=%b want=1", b0.o_ex_illegal); end
    checks++; if ({b0.o_ex_alu_op, b0.o_ex_alu_src, b0.o_ex_auipc_lui, b0.o_ex_fwd_a, b0.o_ex_fwd_b, b0.o_stall, b0.o_flush} !== 13'd0) begin
      errors++; $display("FAIL illegal_ctrl got=%b want=0", {b0.o_ex_alu_op, b0.o_ex_alu_src, b0.o_ex_auipc_lui, b0.o_ex_fwd_a, b0.o_ex_fwd_b, b0.o_stall, b0.o_flush});
    end
    tick();
    set(OP_IMM, 0, 0, 0);
    checks++; if ({b0.o_mem_read, b0.o_mem_write} !== 2'b00) begin errors++; $display("FAIL illegal_mem got=%b want=00", {b0.o_mem_read, b0.o_mem_write}); end
    checks++; if ({b0.o_ex_alu_op, b0.o_ex_alu_src, b0.o_ex_illegal} !== 6'b001010) begin errors++; $display("FAIL sw_ex got=%b want=001010", {b0.o_ex_alu_op, b0.o_ex_alu_src, b0.o_ex_illegal}); end
    tick();
    checks++; if (b0.o_wb_reg_write !== 1'b0) begin errors++; $display("FAIL illegal_wb got=%b want=0", b0.o_wb_reg_write); end
    checks++; if ({b0.o_mem_read, b0.o_mem_write} !== 2'b01) begin errors++; $display("FAIL sw_mem got=%b want=01", {b0.o_mem_read, b0.o_mem_write}); end
    nops();
  endtask
  task automatic test_no_forwarding();
    int n;
    logic fwd_seen;
    n = 0;
    fwd_seen = 1'b0;
    set(OP_R, 4, 1, 2);
    tick();
    set(OP_R, 7, 4, 4);
    for (int i = 0; i < 8; i++) begin
      if (b1.o_ex_fwd_a !== 2'b00 || b1.o_ex_fwd_b !== 2'b00) fwd_seen = 1'b1;
      if (b1.o_stall !== 1'b1) break;
      n++;
      tick();
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL nofwd_stall_cycles got=%0d want=3", n); end
    tick();
    if (b1.o_ex_fwd_a !== 2'b00 || b1.o_ex_fwd_b !== 2'b00) fwd_seen = 1'b1;
    checks++; if (fwd_seen !== 1'b0) begin errors++; $display("FAIL nofwd_fwd_tied got=%b want=0", fwd_seen); end
    checks++; if (b1.o_ex_alu_op !== ALU_RR || b1.o_stall !== 1'b0) begin errors++; $display("FAIL nofwd_issue got=%b/%b want=0000/0", b1.o_ex_alu_op, b1.o_stall); end
    nops();
  endtask
  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_raw_fwd();
    test_branch();
    test_jumps();
    test_illegal_store();
    test_no_forwarding();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
